// File: rtl/sram_burst_reader.sv
// sram_burst_reader
// Reads a burst of consecutive words from a 256x64b registered-read SRAM and
// streams them out on a valid/ready port. A 2-entry output FIFO absorbs the
// one-cycle SRAM latency, so the burst can still move one word per cycle
// while tolerating downstream backpressure.
module sram_burst_reader #(
    parameter int BW_SRAM_ADDR = 8,
    parameter int BW_SRAM_DATA = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [BW_SRAM_ADDR-1:0] base_addr,
    input  logic [BW_SRAM_ADDR:0]   num_words,
    output logic                    busy,
    output logic                    done,
    output logic                    sram_csb,
    output logic                    sram_wsb,
    output logic [BW_SRAM_ADDR-1:0] sram_raddr,
    input  logic [BW_SRAM_DATA-1:0] sram_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BW_SRAM_DATA-1:0] out_data,
    output logic                    out_last
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } state_t;

    state_t                  state_q, state_d;
    logic [BW_SRAM_ADDR-1:0] baseAddr_q, baseAddr_d;
    logic [BW_SRAM_ADDR:0]   numWords_q, numWords_d;
    logic [BW_SRAM_ADDR:0]   issued_q, issued_d;
    logic [BW_SRAM_ADDR:0]   popped_q, popped_d;
    logic                    inflight_q, inflight_d;
    logic [BW_SRAM_DATA-1:0] fifoMem_q [2];
    logic [BW_SRAM_DATA-1:0] fifoMem_d [2];
    logic                    wrPtr_q, wrPtr_d;
    logic                    rdPtr_q, rdPtr_d;
    logic [1:0]              fifoCount_q, fifoCount_d;

    logic                    push;
    logic                    pop;
    logic                    issue;
    logic [2:0]              occupancy;

    // Handshake, issue decision and all next-state values. The slot check
    // subtracts a pop happening in the same cycle: the word requested now
    // only lands in the FIFO one cycle later, after that pop has freed its
    // slot, and without this credit the stream could not sustain one word
    // per cycle.
    always_comb begin
        state_d     = state_q;
        baseAddr_d  = baseAddr_q;
        numWords_d  = numWords_q;
        issued_d    = issued_q;
        popped_d    = popped_q;
        inflight_d  = 1'b0;
        fifoMem_d   = fifoMem_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;

        push        = inflight_q;
        pop         = (fifoCount_q != 2'd0) && out_ready;
        occupancy   = {1'b0, fifoCount_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue       = (state_q == RUN) && (issued_q < numWords_q) && (occupancy < 3'd2);
        fifoCount_d = fifoCount_q + {1'b0, push} - {1'b0, pop};

        if (issue) begin
            issued_d   = issued_q + 1'b1;
            inflight_d = 1'b1;
        end
        if (push) begin
            fifoMem_d[wrPtr_q] = sram_rdata;
            wrPtr_d            = ~wrPtr_q;
        end
        if (pop) begin
            rdPtr_d  = ~rdPtr_q;
            popped_d = popped_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    baseAddr_d = base_addr;
                    numWords_d = num_words;
                    issued_d   = '0;
                    popped_d   = '0;
                    state_d    = (num_words == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (issue && (issued_q + 1'b1 == numWords_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (popped_q + 1'b1 == numWords_q)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any burst and drops a read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            baseAddr_q   <= '0;
            numWords_q   <= '0;
            issued_q     <= '0;
            popped_q     <= '0;
            inflight_q   <= 1'b0;
            fifoMem_q[0] <= '0;
            fifoMem_q[1] <= '0;
            wrPtr_q      <= 1'b0;
            rdPtr_q      <= 1'b0;
            fifoCount_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            baseAddr_q   <= baseAddr_d;
            numWords_q   <= numWords_d;
            issued_q     <= issued_d;
            popped_q     <= popped_d;
            inflight_q   <= inflight_d;
            fifoMem_q    <= fifoMem_d;
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            fifoCount_q  <= fifoCount_d;
        end
    end

    // Output decode; the address adder wraps naturally at the SRAM depth.
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == FIN);
        sram_csb   = ~issue;
        sram_wsb   = 1'b1;
        sram_raddr = baseAddr_q + issued_q[BW_SRAM_ADDR-1:0];
        out_valid  = (fifoCount_q != 2'd0);
        out_data   = fifoMem_q[rdPtr_q];
        out_last   = out_valid && (popped_q == numWords_q - 1'b1);
    end

endmodule

// File: tb/tb_sram_burst_reader.sv
// tb_sram_burst_reader
// Directed bench: a behavioural registered-read SRAM feeds the reader, and
// each scenario task checks the captured read addresses, streamed words and
// control timing against hand-derived values.
module tb_sram_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  num_words;
    logic        busy;
    logic        done;
    logic        sram_csb;
    logic        sram_wsb;
    logic [7:0]  sram_raddr;
    logic [63:0] sram_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;

    int errors = 0;
    int checks = 0;

    logic [63:0] gotData [$];
    logic        gotLast [$];
    logic [7:0]  rdAddr  [$];
    int          rdCyc   [$];
    int          doneSeen, busyCycles, holdErrs, maxBuf, firstValidCyc, doneCyc, lastHsCyc;
    int          wsbErrs = 0;
    bit          timedOut;

    sram_burst_reader #(.BW_SRAM_ADDR(8), .BW_SRAM_DATA(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .busy       (busy),
        .done       (done),
        .sram_csb   (sram_csb),
        .sram_wsb   (sram_wsb),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Memory contents: every address holds a distinct, address-derived word.
    function automatic logic [63:0] memWord(input logic [7:0] a);
        return {a, ~a, 16'hBEEF, a ^ 8'h5A, 8'h00, a, 8'h3C};
    endfunction

    // Registered-read SRAM: data appears the cycle after a selected read.
    always @(posedge clk) begin
        if (!sram_csb) sram_rdata <= memWord(sram_raddr);
    end

    // Starts a burst and records everything observed until done or the cycle limit.
    // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic runBurst(input logic [7:0] base, input logic [8:0] n, input int mode,
                            input bit poke, input int limit);
        int          cyc;
        int          buffered;
        bit          prevStall;
        logic [63:0] prevData;
        logic        prevLast;
        gotData.delete(); gotLast.delete(); rdAddr.delete(); rdCyc.delete();
        doneSeen = 0; busyCycles = 0; holdErrs = 0; maxBuf = 0;
        firstValidCyc = -1; doneCyc = -1; lastHsCyc = -1; timedOut = 1'b1;
        @(negedge clk);
        base_addr = base; num_words = n; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; prevStall = 1'b0; prevData = '0; prevLast = 1'b0;
        while (cyc <= limit) begin
            buffered = rdAddr.size() - gotData.size();
            if (buffered > maxBuf) maxBuf = buffered;
            if (busy) busyCycles++;
            if (prevStall && (!out_valid || out_data !== prevData || out_last !== prevLast)) holdErrs++;
            if (sram_wsb !== 1'b1) wsbErrs++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc - 1) % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (poke && cyc == 5) begin
                start = 1'b1; base_addr = 8'h55; num_words = 9'd3;
            end else begin
                start = 1'b0;
            end
            #1;
            if (!sram_csb) begin
                rdAddr.push_back(sram_raddr);
                rdCyc.push_back(cyc);
            end
            if (out_valid && firstValidCyc < 0) firstValidCyc = cyc;
            if (out_valid && out_ready) begin
                gotData.push_back(out_data);
                gotLast.push_back(out_last);
                lastHsCyc = cyc;
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevLast  = out_last;
            if (done) begin
                doneSeen++;
                doneCyc  = cyc;
                timedOut = 1'b0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    // Reset values of every output.
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; num_words = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (sram_csb !== 1'b1)   begin errors++; $display("[TB] FAIL reset_csb: got %b expected 1", sram_csb); end
        checks++; if (sram_wsb !== 1'b1)   begin errors++; $display("[TB] FAIL reset_wsb: got %b expected 1", sram_wsb); end
        checks++; if (sram_raddr !== 8'h0) begin errors++; $display("[TB] FAIL reset_raddr: got %h expected 00", sram_raddr); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0)   begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", out_last); end
        checks++; if (out_data !== 64'h0)  begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", out_data); end
        rst = 1'b0;
    endtask

    // Base 0x10, 4 words, ready held high: back-to-back reads and 1 word/cycle.
    task automatic test_basic();
        runBurst(8'h10, 9'd4, 0, 1'b0, 50);
        checks++; if (timedOut) begin errors++; $display("[TB] FAIL t1_timeout: got no done expected done"); end
        checks++; if (rdAddr.size() != 4) begin errors++; $display("[TB] FAIL t1_nreads: got %0d expected 4", rdAddr.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rdAddr[i] !== 8'h10 + 8'(i) || rdCyc[i] != i + 1) begin
                errors++; $display("[TB] FAIL t1_read%0d: got addr %h cyc %0d expected addr %h cyc %0d", i, rdAddr[i], rdCyc[i], 8'h10 + 8'(i), i + 1);
            end
            checks++; if (gotData[i] !== memWord(8'h10 + 8'(i)) || gotLast[i] !== (i == 3)) begin
                errors++; $display("[TB] FAIL t1_word%0d: got %h last %b expected %h last %b", i, gotData[i], gotLast[i], memWord(8'h10 + 8'(i)), i == 3);
            end
        end
        checks++; if (firstValidCyc != 3) begin errors++; $display("[TB] FAIL t1_first_valid: got cyc %0d expected 3", firstValidCyc); end
        checks++; if (doneCyc != 7 || lastHsCyc != 6) begin errors++; $display("[TB] FAIL t1_done_cyc: got done %0d lasths %0d expected 7 6", doneCyc, lastHsCyc); end
        checks++; if (busyCycles != 7) begin errors++; $display("[TB] FAIL t1_busy_cycles: got %0d expected 7", busyCycles); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL t1_done_pulse: got done %b busy %b expected 0 0", done, busy); end
    endtask

    // Base 0xFE: address wraps from FF to 00.
    task automatic test_wrap();
        logic [7:0] expAddr [4];
        expAddr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        runBurst(8'hFE, 9'd4, 0, 1'b0, 50);
        checks++; if (rdAddr.size() != 4 || gotData.size() != 4) begin errors++; $display("[TB] FAIL t2_counts: got reads %0d words %0d expected 4 4", rdAddr.size(), gotData.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rdAddr[i] !== expAddr[i] || gotData[i] !== memWord(expAddr[i])) begin
                errors++; $display("[TB] FAIL t2_wrap%0d: got addr %h data %h expected addr %h data %h", i, rdAddr[i], gotData[i], expAddr[i], memWord(expAddr[i]));
            end
        end
    endtask

    // 8 words with ready toggling 1,0,0: order, hold-while-stalled, buffering depth.
    task automatic test_backpressure();
        runBurst(8'h30, 9'd8, 1, 1'b0, 100);
        checks++; if (timedOut || gotData.size() != 8) begin errors++; $display("[TB] FAIL t3_words: got %0d expected 8", gotData.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (gotData[i] !== memWord(8'h30 + 8'(i)) || gotLast[i] !== (i == 7)) begin
                errors++; $display("[TB] FAIL t3_word%0d: got %h last %b expected %h last %b", i, gotData[i], gotLast[i], memWord(8'h30 + 8'(i)), i == 7);
            end
        end
        checks++; if (holdErrs != 0) begin errors++; $display("[TB] FAIL t3_hold: got %0d changes expected 0", holdErrs); end
        checks++; if (maxBuf != 2) begin errors++; $display("[TB] FAIL t3_maxbuf: got %0d expected 2", maxBuf); end
        checks++; if (rdAddr.size() != 8) begin errors++; $display("[TB] FAIL t3_nreads: got %0d expected 8", rdAddr.size()); end
    endtask

    // Zero-length burst: no SRAM access, busy one cycle together with done.
    task automatic test_zero_len();
        runBurst(8'h33, 9'd0, 0, 1'b0, 20);
        checks++; if (rdAddr.size() != 0) begin errors++; $display("[TB] FAIL t4_reads: got %0d expected 0", rdAddr.size()); end
        checks++; if (doneCyc != 1 || busyCycles != 1) begin errors++; $display("[TB] FAIL t4_timing: got done %0d busy %0d expected 1 1", doneCyc, busyCycles); end
        checks++; if (firstValidCyc != -1) begin errors++; $display("[TB] FAIL t4_valid: got valid at %0d expected never", firstValidCyc); end
    endtask

    // Reset after 3 of 10 words: immediate abort, no done, then a clean burst.
    task automatic test_reset_mid();
        int hs = 0;
        int guard = 0;
        int doneHits = 0;
        int csbLow = 0;
        @(negedge clk);
        base_addr = 8'h20; num_words = 9'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1;
        while (hs < 3 && guard < 50) begin
            if (out_valid && out_ready) hs++;
            @(negedge clk);
            guard++;
        end
        checks++; if (hs != 3) begin errors++; $display("[TB] FAIL t5_prefix: got %0d words expected 3", hs); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sram_csb !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            errors++; $display("[TB] FAIL t5_abort_ctrl: got busy %b done %b csb %b valid %b last %b expected 0 0 1 0 0", busy, done, sram_csb, out_valid, out_last);
        end
        checks++; if (sram_raddr !== 8'h0 || out_data !== 64'h0) begin
            errors++; $display("[TB] FAIL t5_abort_data: got raddr %h data %h expected 00 0", sram_raddr, out_data);
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) doneHits++;
            if (!sram_csb || out_valid) csbLow++;
        end
        checks++; if (doneHits != 0 || csbLow != 0) begin errors++; $display("[TB] FAIL t5_quiet: got done %0d activity %0d expected 0 0", doneHits, csbLow); end
        out_ready = 1'b0;
        runBurst(8'h40, 9'd3, 0, 1'b0, 50);
        checks++; if (gotData.size() != 3 || gotData[0] !== memWord(8'h40) || gotData[2] !== memWord(8'h42) || gotLast[2] !== 1'b1) begin
            errors++; $display("[TB] FAIL t5_restart: got %0d words first %h expected 3 words first %h", gotData.size(), gotData[0], memWord(8'h40));
        end
    endtask

    // Start accepted in the IDLE cycle right after done.
    task automatic test_back_to_back();
        logic [63:0] firstWord;
        runBurst(8'h00, 9'd2, 0, 1'b0, 50);
        firstWord = gotData[0];
        runBurst(8'h08, 9'd2, 0, 1'b0, 50);
        checks++; if (firstWord !== memWord(8'h00)) begin errors++; $display("[TB] FAIL b2b_first: got %h expected %h", firstWord, memWord(8'h00)); end
        checks++; if (rdCyc.size() != 2 || rdCyc[0] != 1 || gotData[1] !== memWord(8'h09)) begin
            errors++; $display("[TB] FAIL b2b_second: got reads %0d data %h expected 2 %h", rdCyc.size(), gotData[1], memWord(8'h09));
        end
    endtask

    // Full-depth burst under random ready, with a start poked while busy.
    task automatic test_full_depth();
        bit seen [256];
        int dups = 0;
        int dataErrs = 0;
        int lastErrs = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        runBurst(8'h80, 9'd256, 2, 1'b1, 3000);
        checks++; if (timedOut) begin errors++; $display("[TB] FAIL t6_timeout: got no done expected done"); end
        checks++; if (gotData.size() != 256 || rdAddr.size() != 256) begin
            errors++; $display("[TB] FAIL t6_counts: got words %0d reads %0d expected 256 256", gotData.size(), rdAddr.size());
        end
        foreach (rdAddr[i]) begin
            if (seen[rdAddr[i]]) dups++;
            seen[rdAddr[i]] = 1'b1;
        end
        foreach (gotData[i]) begin
            if (gotData[i] !== memWord(8'h80 + 8'(i))) dataErrs++;
            if (gotLast[i] !== (i == 255)) lastErrs++;
        end
        checks++; if (dups != 0) begin errors++; $display("[TB] FAIL t6_dup_addr: got %0d duplicates expected 0", dups); end
        checks++; if (dataErrs != 0) begin errors++; $display("[TB] FAIL t6_data: got %0d bad words expected 0", dataErrs); end
        checks++; if (lastErrs != 0) begin errors++; $display("[TB] FAIL t6_last: got %0d bad flags expected 0", lastErrs); end
        checks++; if (holdErrs != 0 || maxBuf > 2) begin errors++; $display("[TB] FAIL t6_flow: got hold %0d maxbuf %0d expected 0 <=2", holdErrs, maxBuf); end
        checks++; if (wsbErrs != 0) begin errors++; $display("[TB] FAIL wsb_high: got %0d low cycles expected 0", wsbErrs); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL t6_idle_after: got busy %b valid %b expected 0 0", busy, out_valid); end
    endtask

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        test_full_depth();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
